// File: rtl/usb3_link_pkg.sv
// Shared constants, state encoding and CRC-5 helper for the USB 3.0 link-layer framer.
// Also intended for reuse by the transmit path.
package usb3_link_pkg;

  localparam logic [7:0] K_SHP = 8'h5C;
  localparam logic [7:0] K_SLC = 8'h9C;
  localparam logic [7:0] K_EPF = 8'hF7;
  localparam logic [7:0] K_SDP = 8'h7C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hDC;

  localparam logic [31:0] HPSTART_DW = {K_SHP, K_SHP, K_SHP, K_EPF};
  localparam logic [31:0] LCSTART_DW = {K_SLC, K_SLC, K_SLC, K_EPF};

  localparam logic [15:0] CRC16_POLY = 16'h100B;
  localparam logic [15:0] CRC16_SEED = 16'hFFFF;
  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [4:0]  CRC5_SEED  = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HP_D0,
    ST_HP_D1,
    ST_HP_D2,
    ST_HP_TAIL,
    ST_LC_W
  } rx_state_e;

  // Bit 0 of the link control word enters the CRC first; result is inverted.
  function automatic logic [4:0] crc5_calc(input logic [10:0] data);
    logic [4:0] r;
    logic       fb;
    r = CRC5_SEED;
    for (int i = 0; i < 11; i++) begin
      fb = r[4] ^ data[i];
      r  = {r[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
    end
    return ~r;
  endfunction

  function automatic logic crc5_ok(input logic [15:0] word);
    return word[15:11] == crc5_calc(word[10:0]);
  endfunction

endpackage

// File: rtl/usb3_link_rx_if.sv
// Symbol stream in and decoded header packet / link command out of the framer.
interface usb3_link_rx_if #(
  parameter int ERR_CNT_W = 8
);
  logic [31:0]          in_data;
  logic [3:0]           in_datak;
  logic                 in_active;
  logic [95:0]          hp_data;
  logic [15:0]          hp_lcw;
  logic                 hp_valid;
  logic                 hp_crc16_ok;
  logic                 hp_crc5_ok;
  logic [15:0]          lc_word;
  logic                 lc_valid;
  logic                 lc_ok;
  logic                 framing_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_data, in_datak, in_active,
    input  hp_data, hp_lcw, hp_valid, hp_crc16_ok, hp_crc5_ok,
    input  lc_word, lc_valid, lc_ok, framing_err, err_count
  );

  modport slave (
    input  in_data, in_datak, in_active,
    output hp_data, hp_lcw, hp_valid, hp_crc16_ok, hp_crc5_ok,
    output lc_word, lc_valid, lc_ok, framing_err, err_count
  );
endinterface

// File: rtl/usb3_crc16_d32.sv
// One-dword parallel step of the link CRC-16: bytes in wire order (data_in[31:24] first),
// each byte LSB-first.
module usb3_crc16_d32
  import usb3_link_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [31:0] data_in,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] w_c;
    logic        w_fb;
    // NOTE: blocking assignments here so each unrolled bit step sees the previous one.
    w_c = crc_in;
    for (int b = 3; b >= 0; b--) begin
      for (int i = 0; i < 8; i++) begin
        w_fb = w_c[15] ^ data_in[8*b+i];
        w_c  = {w_c[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
      end
    end
    crc_out = w_c;
  end

endmodule

// File: rtl/usb3_link_rx.sv
// Receive framer: finds HPSTART/LCSTART ordered sets, collects header packets and link
// commands, checks CRC-16/CRC-5 and counts framing and CRC errors.
module usb3_link_rx
  import usb3_link_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input logic           local_clk,
  input logic           reset,
  usb3_link_rx_if.slave link
);

  rx_state_e            r_state;
  logic [15:0]          r_crc;
  logic [95:0]          r_hp_buf;
  logic [95:0]          r_hp_data;
  logic [15:0]          r_hp_lcw;
  logic                 r_hp_valid;
  logic                 r_hp_crc16_ok;
  logic                 r_hp_crc5_ok;
  logic [15:0]          r_lc_word;
  logic                 r_lc_valid;
  logic                 r_lc_ok;
  logic                 r_framing_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic [15:0] w_crc_next;
  logic        w_is_hpstart;
  logic        w_is_lcstart;
  logic        w_abort;
  logic        w_hp_done;
  logic        w_lc_done;
  logic [15:0] w_rx_crc16;
  logic [15:0] w_lcw;
  logic [15:0] w_copy0;
  logic [15:0] w_copy1;
  logic        w_hp_crc16_ok;
  logic        w_hp_crc5_ok;
  logic        w_lc_ok;
  logic        w_err_event;

  usb3_crc16_d32 u_crc16 (
    .crc_in  (r_crc),
    .data_in (link.in_data),
    .crc_out (w_crc_next)
  );

  assign w_is_hpstart = (link.in_datak == 4'hF) && (link.in_data == HPSTART_DW);
  assign w_is_lcstart = (link.in_datak == 4'hF) && (link.in_data == LCSTART_DW);

  // Any K byte while inside a frame aborts it, including a fresh start ordered set.
  assign w_abort   = link.in_active && (r_state != ST_IDLE) && (link.in_datak != 4'h0);
  assign w_hp_done = link.in_active && (r_state == ST_HP_TAIL) && (link.in_datak == 4'h0);
  assign w_lc_done = link.in_active && (r_state == ST_LC_W) && (link.in_datak == 4'h0);

  // Two-byte fields arrive low byte first on the wire.
  assign w_rx_crc16 = {link.in_data[23:16], link.in_data[31:24]};
  assign w_lcw      = {link.in_data[7:0], link.in_data[15:8]};
  assign w_copy0    = w_rx_crc16;
  assign w_copy1    = w_lcw;

  assign w_hp_crc16_ok = (w_rx_crc16 == ~r_crc);
  assign w_hp_crc5_ok  = crc5_ok(w_lcw);
  assign w_lc_ok       = (w_copy0 == w_copy1) && crc5_ok(w_copy0);

  assign w_err_event = w_abort
                     | (w_hp_done & ~(w_hp_crc16_ok & w_hp_crc5_ok))
                     | (w_lc_done & ~w_lc_ok);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_crc         <= CRC16_SEED;
      r_hp_buf      <= '0;
      r_hp_data     <= '0;
      r_hp_lcw      <= '0;
      r_hp_valid    <= 1'b0;
      r_hp_crc16_ok <= 1'b0;
      r_hp_crc5_ok  <= 1'b0;
      r_lc_word     <= '0;
      r_lc_valid    <= 1'b0;
      r_lc_ok       <= 1'b0;
      r_framing_err <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_hp_valid    <= 1'b0;
      r_lc_valid    <= 1'b0;
      r_framing_err <= 1'b0;

      if (w_err_event && (r_err_count != '1))
        r_err_count <= r_err_count + ERR_CNT_W'(1);

      if (link.in_active) begin
        if (w_abort) begin
          r_framing_err <= 1'b1;
          if (w_is_hpstart) begin
            r_state <= ST_HP_D0;
            r_crc   <= CRC16_SEED;
          end else if (w_is_lcstart) begin
            r_state <= ST_LC_W;
          end else begin
            r_state <= ST_IDLE;
          end
        end else begin
          unique case (r_state)
            ST_IDLE: begin
              if (w_is_hpstart) begin
                r_state <= ST_HP_D0;
                r_crc   <= CRC16_SEED;
              end else if (w_is_lcstart) begin
                r_state <= ST_LC_W;
              end
            end
            ST_HP_D0: begin
              r_hp_buf[95:64] <= link.in_data;
              r_crc           <= w_crc_next;
              r_state         <= ST_HP_D1;
            end
            ST_HP_D1: begin
              r_hp_buf[63:32] <= link.in_data;
              r_crc           <= w_crc_next;
              r_state         <= ST_HP_D2;
            end
            ST_HP_D2: begin
              r_hp_buf[31:0] <= link.in_data;
              r_crc          <= w_crc_next;
              r_state        <= ST_HP_TAIL;
            end
            ST_HP_TAIL: begin
              r_hp_data     <= r_hp_buf;
              r_hp_lcw      <= w_lcw;
              r_hp_crc16_ok <= w_hp_crc16_ok;
              r_hp_crc5_ok  <= w_hp_crc5_ok;
              r_hp_valid    <= 1'b1;
              r_state       <= ST_IDLE;
            end
            ST_LC_W: begin
              r_lc_word  <= w_copy0;
              r_lc_ok    <= w_lc_ok;
              r_lc_valid <= 1'b1;
              r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign link.hp_data     = r_hp_data;
  assign link.hp_lcw      = r_hp_lcw;
  assign link.hp_valid    = r_hp_valid;
  assign link.hp_crc16_ok = r_hp_crc16_ok;
  assign link.hp_crc5_ok  = r_hp_crc5_ok;
  assign link.lc_word     = r_lc_word;
  assign link.lc_valid    = r_lc_valid;
  assign link.lc_ok       = r_lc_ok;
  assign link.framing_err = r_framing_err;
  assign link.err_count   = r_err_count;

endmodule
